// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Definitions shared by the vector add/sub datapath blocks: the default
// element width and vector length, the opcode encodings, the operand-loader
// state encoding, and a helper that sizes element index counters.
// This package has no ports.
// -----------------------------------------------------------------------------
package vec_pkg;

    localparam int DEF_ELEM_W = 8;
    localparam int DEF_VLEN   = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        LOAD_V1 = 2'd0,
        LOAD_V2 = 2'd1,
        ISSUE   = 2'd2
    } ld_state_e;

    // Index counter width. A single-element vector still needs a 1-bit index.
    function automatic int idx_width(input int vlen);
        return (vlen > 1) ? $clog2(vlen) : 1;
    endfunction

endpackage

// File: rtl/vec_elem_counter.sv
// -----------------------------------------------------------------------------
// vec_elem_counter
// Wrapping element index counter, 0..VLEN-1. It is shared by the operand
// loader and the result-side unloader.
//
// Ports:
//   clk   in  : clock
//   rst   in  : synchronous active-high reset, which clears idx to 0
//   inc   in  : advance idx; it wraps to 0 after VLEN-1
//   clear in  : force idx to 0; takes priority over inc
//   idx   out : current element index
//   last  out : idx == VLEN-1
// -----------------------------------------------------------------------------
module vec_elem_counter
    import vec_pkg::*;
#(
    parameter  int VLEN  = DEF_VLEN,
    localparam int IDX_W = idx_width(VLEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign last = (idx_q == IDX_W'(VLEN - 1));
    assign idx  = idx_q;

    always_comb begin
        // NOTE: assign a default first, so that every path through the block
        // drives idx_d and no latch is inferred.
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments only. Every flop then
    // samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/vec_operand_loader.sv
// -----------------------------------------------------------------------------
// vec_operand_loader
// Takes a serial stream of elements and packs it into two VLEN-element operand
// vectors plus an opcode. The complete bundle is then offered to the vector ALU
// stage under a valid/ready handshake.
//
// Optional feature: define VEC_LOADER_ABORT_EN to add the in_abort port. In_abort
// discards a partially loaded bundle.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   in_valid/in_ready/in_data : element stream handshake and element value
//   in_op         : opcode, sampled only with vec1 element 0
//   in_abort      : (VEC_LOADER_ABORT_EN only) drops the partial bundle
//   out_valid/out_ready : bundle handshake towards the ALU stage
//   out_vec1/out_vec2   : packed vectors; element i at [i*ELEM_W +: ELEM_W]
//   out_opcode    : opcode of the bundle
//   issued_cnt    : bundles handed off, modulo 2^16
// -----------------------------------------------------------------------------
module vec_operand_loader
    import vec_pkg::*;
#(
    parameter int ELEM_W = DEF_ELEM_W,
    parameter int VLEN   = DEF_VLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ELEM_W-1:0]      in_data,
    input  logic                   in_op,
`ifdef VEC_LOADER_ABORT_EN
    input  logic                   in_abort,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VLEN*ELEM_W-1:0] out_vec1,
    output logic [VLEN*ELEM_W-1:0] out_vec2,
    output logic                   out_opcode,
    output logic [15:0]            issued_cnt
);

    localparam int IDX_W = idx_width(VLEN);

    ld_state_e              state_q, state_d;
    logic [VLEN*ELEM_W-1:0] vec1_q, vec1_d;
    logic [VLEN*ELEM_W-1:0] vec2_q, vec2_d;
    logic                   opcode_q, opcode_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [IDX_W-1:0] idx;
    logic             idx_last;
    logic             accept;
    logic             handoff;
    logic             abort_hit;

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

`ifdef VEC_LOADER_ABORT_EN
    // Abort has no effect in ISSUE. A complete bundle is always delivered.
    assign abort_hit = in_abort && (state_q != ISSUE);
`else
    assign abort_hit = 1'b0;
`endif

    vec_elem_counter #(.VLEN(VLEN)) u_idx (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clear (abort_hit),
        .idx   (idx),
        .last  (idx_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_V1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_V1: begin
                if (abort_hit)             state_d = LOAD_V1;
                else if (accept && idx_last) state_d = LOAD_V2;
            end
            LOAD_V2: begin
                if (abort_hit)             state_d = LOAD_V1;
                else if (accept && idx_last) state_d = ISSUE;
            end
            ISSUE: begin
                if (handoff) state_d = LOAD_V1;
            end
            default: state_d = LOAD_V1;
        endcase
    end

    // Output logic. No bypass: in_ready stays low for all of ISSUE.
    always_comb begin
        out_valid = (state_q == ISSUE);
`ifdef VEC_LOADER_ABORT_EN
        in_ready  = (state_q != ISSUE) && !in_abort;
`else
        in_ready  = (state_q != ISSUE);
`endif
    end

    // Element storage, opcode capture and handoff counter. The decode is a
    // loop over elements rather than a variable part-select. It yields one
    // write enable per element slot.
    always_comb begin
        vec1_d   = vec1_q;
        vec2_d   = vec2_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        if (accept) begin
            for (int i = 0; i < VLEN; i++) begin
                if (idx == IDX_W'(i)) begin
                    if (state_q == LOAD_V1) vec1_d[i*ELEM_W +: ELEM_W] = in_data;
                    else                    vec2_d[i*ELEM_W +: ELEM_W] = in_data;
                end
            end
            if (state_q == LOAD_V1 && idx == '0) opcode_d = in_op;
        end
        if (handoff) cnt_d = cnt_q + 16'd1;
    end

    // NOTE: the vector registers are reset even though their contents matter
    // only in ISSUE. The outputs must read zero out of reset, which rules out
    // leaving them unreset as plain memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec1_q   <= '0;
            vec2_q   <= '0;
            opcode_q <= OP_ADD;
            cnt_q    <= '0;
        end else begin
            vec1_q   <= vec1_d;
            vec2_q   <= vec2_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_vec1   = vec1_q;
    assign out_vec2   = vec2_q;
    assign out_opcode = opcode_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_vec_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_vec_operand_loader
// Directed testbench for vec_operand_loader with ELEM_W=8 and VLEN=4. Inputs
// change 1 ns after each rising edge. Outputs are checked in the same window,
// which keeps every check away from the active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vec_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_op;
`ifdef VEC_LOADER_ABORT_EN
    logic        in_abort;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_vec1;
    logic [31:0] out_vec2;
    logic        out_opcode;
    logic [15:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_operand_loader #(.ELEM_W(8), .VLEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
`ifdef VEC_LOADER_ABORT_EN
        .in_abort   (in_abort),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec1   (out_vec1),
        .out_vec2   (out_vec2),
        .out_opcode (out_opcode),
        .issued_cnt (issued_cnt)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one element for one cycle. in_ready must be high for the
    // element to be taken.
    task automatic send_elem(input logic [7:0] data, input logic op);
        in_valid = 1'b1;
        in_data  = data;
        in_op    = op;
        check("send_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Presents junk data with in_valid low, which must not be stored.
    task automatic bubble();
        in_valid = 1'b0;
        in_data  = 8'hEE;
        in_op    = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] snap1;
        logic [31:0] snap2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        int          sent;
        int          got;
        int          last_rise;
        logic        acc;
        logic [7:0]  bdl;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        out_ready = 1'b1;
`ifdef VEC_LOADER_ABORT_EN
        in_abort  = 1'b0;
`endif
        tick();
        tick();

        // ---------------- Reset values ----------------
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_vec1", 64'(out_vec1), 64'd0);
        check("rst_vec2", 64'(out_vec2), 64'd0);
        check("rst_opcode", 64'(out_opcode), 64'd0);
        check("rst_cnt", 64'(issued_cnt), 64'd0);
        rst = 1'b0;

        // ---------------- Basic pack ----------------
        send_elem(8'h01, 1'b1);
        send_elem(8'h02, 1'b0);
        send_elem(8'h03, 1'b0);
        send_elem(8'h04, 1'b0);
        send_elem(8'h0A, 1'b0);
        send_elem(8'h14, 1'b0);
        send_elem(8'h1E, 1'b0);
        check("basic_not_valid_early", 64'(out_valid), 64'd0);
        send_elem(8'h28, 1'b0);
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_in_ready_issue", 64'(in_ready), 64'd0);
        check("basic_vec1", 64'(out_vec1), 64'h04030201);
        check("basic_vec2", 64'(out_vec2), 64'h281E140A);
        check("basic_opcode", 64'(out_opcode), 64'd1);
        tick();
        check("basic_valid_one_cycle", 64'(out_valid), 64'd0);
        check("basic_cnt", 64'(issued_cnt), 64'd1);
        check("basic_ready_after", 64'(in_ready), 64'd1);

        // ---------------- Backpressure ----------------
        out_ready = 1'b0;
        send_elem(8'h11, 1'b0);
        send_elem(8'h22, 1'b1);
        send_elem(8'h33, 1'b1);
        send_elem(8'h44, 1'b1);
        send_elem(8'hA1, 1'b1);
        send_elem(8'hB2, 1'b1);
        send_elem(8'hC3, 1'b1);
        send_elem(8'hD4, 1'b1);
        snap1 = out_vec1;
        snap2 = out_vec2;
        check("bp_vec1", 64'(out_vec1), 64'h44332211);
        check("bp_vec2", 64'(out_vec2), 64'hD4C3B2A1);
        check("bp_opcode", 64'(out_opcode), 64'd0);
        // The producer keeps pushing 0x55 throughout. It must not be taken
        // while the bundle waits.
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_op    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_vec1_stable", 64'(out_vec1), 64'(snap1));
            check("bp_vec2_stable", 64'(out_vec2), 64'(snap2));
            tick();
        end
        check("bp_cnt_held", 64'(issued_cnt), 64'd1);
        out_ready = 1'b1;
        check("bp_handoff_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("bp_cnt", 64'(issued_cnt), 64'd2);
        check("bp_valid_drop", 64'(out_valid), 64'd0);
        check("bp_ready_next", 64'(in_ready), 64'd1);

        // ---------------- Bubbles ----------------
        // 0x55 is still on the bus with in_valid high. It becomes element 0
        // with in_op=0. Elements 1..7 carry in_op=1, and junk appears on every
        // bubble cycle.
        tick();
        in_valid = 1'b0;
        bubble();
        send_elem(8'h66, 1'b1); bubble();
        send_elem(8'h77, 1'b1); bubble();
        send_elem(8'h88, 1'b1); bubble();
        send_elem(8'h99, 1'b1); bubble();
        send_elem(8'hAA, 1'b1); bubble();
        send_elem(8'hBB, 1'b1); bubble();
        check("bub_not_valid_early", 64'(out_valid), 64'd0);
        send_elem(8'hCC, 1'b1);
        check("bub_valid", 64'(out_valid), 64'd1);
        check("bub_vec1", 64'(out_vec1), 64'h88776655);
        check("bub_vec2", 64'(out_vec2), 64'hCCBBAA99);
        check("bub_opcode", 64'(out_opcode), 64'd0);
        tick();
        check("bub_cnt", 64'(issued_cnt), 64'd3);

        // ---------------- Back-to-back ----------------
        // Element k of bundle b is b*16+k+1. Element 0 carries opcode b[0],
        // and the other elements carry its inverse.
        sent      = 0;
        got       = 0;
        last_rise = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bdl      = 8'(sent / 8);
            in_valid = (sent < 24);
            in_data  = 8'(bdl * 16 + (sent % 8) + 1);
            in_op    = ((sent % 8) == 0) ? bdl[0] : ~bdl[0];
            acc      = in_valid && in_ready;
            tick();
            if (acc) sent++;
            if (out_valid) begin
                bdl  = 8'(got);
                exp1 = {8'(bdl*16+4), 8'(bdl*16+3), 8'(bdl*16+2), 8'(bdl*16+1)};
                exp2 = {8'(bdl*16+8), 8'(bdl*16+7), 8'(bdl*16+6), 8'(bdl*16+5)};
                check("b2b_vec1", 64'(out_vec1), 64'(exp1));
                check("b2b_vec2", 64'(out_vec2), 64'(exp2));
                check("b2b_opcode", 64'(out_opcode), 64'(bdl[0]));
                if (last_rise >= 0) check("b2b_period", 64'(cyc - last_rise), 64'd9);
                last_rise = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        check("b2b_bundles", 64'(got), 64'd3);
        check("b2b_elems", 64'(sent), 64'd24);
        check("b2b_cnt", 64'(issued_cnt), 64'd6);

        // ---------------- Reset mid-op ----------------
        for (int k = 0; k < 5; k++) send_elem(8'(8'hF0 + k), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_vec1", 64'(out_vec1), 64'd0);
        check("mid_rst_cnt", 64'(issued_cnt), 64'd0);
        for (int k = 0; k < 8; k++) send_elem(8'(k + 1), (k == 0));
        check("mid_rst_bvalid", 64'(out_valid), 64'd1);
        check("mid_rst_bvec1", 64'(out_vec1), 64'h04030201);
        check("mid_rst_bvec2", 64'(out_vec2), 64'h08070605);
        check("mid_rst_bop", 64'(out_opcode), 64'd1);
        tick();
        check("mid_rst_cnt_one", 64'(issued_cnt), 64'd1);

        // Reset while a bundle waits in ISSUE drops it uncounted.
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_elem(8'(k + 8'h30), 1'b0);
        check("issue_rst_pre", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("issue_rst_valid", 64'(out_valid), 64'd0);
        check("issue_rst_ready", 64'(in_ready), 64'd1);
        check("issue_rst_cnt", 64'(issued_cnt), 64'd0);

`ifdef VEC_LOADER_ABORT_EN
        // ---------------- Abort ----------------
        for (int k = 0; k < 6; k++) send_elem(8'(k + 8'h70), 1'b1);
        in_abort = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        check("abort_ready_low", 64'(in_ready), 64'd0);
        tick();
        in_abort = 1'b0;
        in_valid = 1'b0;
        check("abort_state", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) send_elem(8'(k + 8'h21), (k == 0));
        check("abort_valid", 64'(out_valid), 64'd1);
        check("abort_vec1", 64'(out_vec1), 64'h24232221);
        check("abort_vec2", 64'(out_vec2), 64'h28272625);
        check("abort_opcode", 64'(out_opcode), 64'd1);
        in_abort = 1'b1;
        tick();
        tick();
        check("abort_issue_hold", 64'(out_valid), 64'd1);
        check("abort_issue_vec1", 64'(out_vec1), 64'h24232221);
        out_ready = 1'b1;
        tick();
        in_abort = 1'b0;
        check("abort_issue_done", 64'(out_valid), 64'd0);
        check("abort_cnt", 64'(issued_cnt), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_operand_loader.md
# vec_operand_loader

Serial-to-parallel operand loader for the Cray-1-style vector add/sub datapath. Accepts a stream of 8-bit elements over a valid/ready handshake and packs them into two VLEN-element operand vectors plus an opcode. It then presents the complete bundle in parallel to the downstream vector ALU stage under a second valid/ready handshake. It is the writer side of the ALU's parallel operand interface.

## Interface
- ELEM_W, default 8: element width in bits.
- VLEN, default 4: elements per vector.
- clk  in  1: clock; all state changes on posedge.
- rst  in  1: reset; synchronous, active-high.
- in_valid  in  1: producer has an element on in_data.
- in_ready  out  1: loader accepts an element this cycle.
- in_data  in  ELEM_W: element value.
- in_op  in  1: opcode (0 = add, 1 = subtract); sampled only with element 0 of vec1.
- in_abort  in  1: discard the partial bundle. Present only when VEC_LOADER_ABORT_EN is defined.
- out_valid  out  1: bundle valid.
- out_ready  in  1: ALU stage takes the bundle.
- out_vec1  out  VLEN*ELEM_W: vector 1; element i (0-based) at bits [i*ELEM_W +: ELEM_W].
- out_vec2  out  VLEN*ELEM_W: vector 2, same packing.
- out_opcode  out  1: opcode of the bundle.
- issued_cnt  out  16: number of bundles handed off, modulo 2^16.

## Operation
- FSM states:
  - LOAD_V1: fills vec1.
  - LOAD_V2: fills vec2.
  - ISSUE: holds the complete bundle.
- Element index register idx runs 0..VLEN-1.
- Accept condition: in_valid && in_ready.
  - LOAD_V1: element goes to vec1[idx]. If idx==0, in_op is captured into out_opcode.
  - LOAD_V2: element goes to vec2[idx].
- Index and state advance on accept:
  - idx==VLEN-1: idx wraps to 0 and the state advances (LOAD_V1→LOAD_V2, LOAD_V2→ISSUE).
  - Otherwise idx increments.
- in_ready = (state != ISSUE), and with the macro defined additionally requires !in_abort.
- out_valid = (state == ISSUE).
- Handoff: out_valid && out_ready causes ISSUE→LOAD_V1 and issued_cnt+1. issued_cnt wraps 0xFFFF→0x0000.
- While out_valid=1 and out_ready=0, out_vec1, out_vec2 and out_opcode hold stable.
- Outside ISSUE, out_vec1/out_vec2 show partially overwritten contents. They are only meaningful while out_valid=1.
- Arithmetic:
  - Elements are stored unmodified.
  - idx is a $clog2(VLEN)-bit counter (minimum 1 bit).
  - VLEN must be ≥1.
- Reset values:
  - state=LOAD_V1, idx=0, so in_ready=1.
  - out_valid=0.
  - out_vec1=0, out_vec2=0, out_opcode=0.
  - issued_cnt=0.
- Reset mid-bundle discards all partially loaded elements, including a pending ISSUE bundle. issued_cnt is not incremented for the discarded bundle.

## Timing
- An element is captured on the edge where the handshake holds.
- out_valid rises the cycle after the final (2*VLEN-th) element is accepted.
- There is no bypass:
  - in_ready=0 throughout ISSUE, including the handoff cycle.
  - The first element of the next bundle is accepted at the earliest in the cycle after the handoff.
- Minimum bundle period: 2*VLEN+1 cycles (9 at VLEN=4).
- issued_cnt updates on the handoff edge, visible the next cycle.
- in_op is ignored on every element other than vec1 element 0.

## Configuration
- VEC_LOADER_ABORT_EN defined:
  - in_abort port exists.
  - in_abort=1 in LOAD_V1 or LOAD_V2 forces state=LOAD_V1 and idx=0 at the next edge.
  - in_ready=0 that cycle, so no element is captured.
  - in_abort is ignored in ISSUE; a complete bundle is always delivered.
  - issued_cnt is unaffected.
- VEC_LOADER_ABORT_EN undefined:
  - No in_abort port.
  - Partial bundles can only be cleared by rst.

## Structure
- Shared package vec_pkg holds:
  - ELEM_W and VLEN defaults.
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - Loader state enum {LOAD_V1, LOAD_V2, ISSUE}.
- One natural sub-module: vec_elem_counter. It is a wrapping 0..VLEN-1 index counter with inc and clear inputs and a last flag, and it is reused by the result-side unloader.
- Element storage, FSM and issued_cnt stay in vec_operand_loader.

## Test plan
- Basic pack: after rst, stream 01,02,03,04,0A,14,1E,28 with in_op=1 on the first element and out_ready=1 → out_valid=1 for exactly one cycle after the 8th accept; out_vec1=0x04030201, out_vec2=0x281E140A, out_opcode=1; issued_cnt=1.
- Backpressure: same stream with out_ready=0 for 5 cycles → outputs stable and in_ready=0 for all 5 cycles; raising out_ready completes the handoff; the next element is accepted one cycle later.
- Bubbles: toggle in_valid 1,0,1,0 → only handshaked elements are stored; the result equals the unbubbled case; in_op=0 on element 0 and 1 on elements 1..7 → out_opcode=0.
- Back-to-back: 3 bundles with in_valid and out_ready held at 1 → period 9 cycles each; issued_cnt=3; no element is lost or duplicated.
- Reset mid-op: assert rst after 5 accepts → next cycle in_ready=1, out_valid=0; a fresh 8-element stream produces a correct bundle; issued_cnt counts only that one.
- Abort (macro defined): in_abort after 6 accepts, with in_valid=1 and data 0xFF on the same cycle → 0xFF not captured, idx=0; the next 8 elements form the bundle. Abort asserted in ISSUE → bundle still delivered.
